// File: rtl/fp32_pkg.sv
// Shared binary32 constants, FSM state encoding and small helpers for the
// iterative floating-point datapath units (multiplier, divider).
package fp32_pkg;

  localparam logic [31:0]       FP32_NAN         = 32'hFFC0_0000;
  localparam logic [7:0]        FP32_INF_EXP     = 8'd255;
  localparam logic signed [9:0] FP32_BIAS        = 10'sd127;
  localparam logic signed [9:0] FP32_EMIN        = -10'sd126;
  localparam logic signed [9:0] FP32_EMAX        = 10'sd127;
  // Unbiased exponents of the all-ones and all-zeros exponent fields.
  localparam logic signed [9:0] FP32_EXP_SPECIAL = 10'sd128;
  localparam logic signed [9:0] FP32_EXP_ZERO    = -10'sd127;

  localparam logic [3:0] StGetA         = 4'd0;
  localparam logic [3:0] StGetB         = 4'd1;
  localparam logic [3:0] StUnpack       = 4'd2;
  localparam logic [3:0] StSpecialCases = 4'd3;
  localparam logic [3:0] StNormaliseA   = 4'd4;
  localparam logic [3:0] StNormaliseB   = 4'd5;
  localparam logic [3:0] StDivide0      = 4'd6;
  localparam logic [3:0] StDivide1      = 4'd7;
  localparam logic [3:0] StDivide2      = 4'd8;
  localparam logic [3:0] StDivide3      = 4'd9;
  localparam logic [3:0] StNormalise1   = 4'd10;
  localparam logic [3:0] StNormalise2   = 4'd11;
  localparam logic [3:0] StRound        = 4'd12;
  localparam logic [3:0] StPack         = 4'd13;
  localparam logic [3:0] StPutZ         = 4'd14;

  function automatic logic [31:0] fp32_inf(input logic sign);
    return {sign, FP32_INF_EXP, 23'd0};
  endfunction

  function automatic logic [31:0] fp32_zero(input logic sign);
    return {sign, 31'd0};
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even and binary32 packing of a normalised significand with
// guard/round/sticky bits. Purely combinational so it can share a state with the caller.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic              z_s,
  input  logic signed [9:0] z_e,
  input  logic [23:0]       z_m,
  input  logic              guard,
  input  logic              round_bit,
  input  logic              sticky,
  output logic [31:0]       z
);

  logic              round_up;
  logic [23:0]       m_rnd;
  logic signed [9:0] e_rnd;
  logic [7:0]        e_field;

  always_comb begin
    round_up = guard & (round_bit | sticky | z_m[0]);
    m_rnd    = z_m + {23'd0, round_up};
    // An all-ones significand wraps to zero; the carry moves into the exponent.
    e_rnd    = (round_up && (z_m == 24'hFF_FFFF)) ? z_e + 10'sd1 : z_e;
    e_field  = e_rnd[7:0] + FP32_BIAS[7:0];
    if ((e_rnd == FP32_EMIN) && !m_rnd[23]) begin
      e_field = 8'd0;
    end
    if (e_rnd > FP32_EMAX) begin
      z = fp32_inf(z_s);
    end else begin
      z = {z_s, e_field, m_rnd[22:0]};
    end
  end

endmodule

// File: rtl/single_divider.sv
// Iterative IEEE-754 binary32 divider z = a / b, restoring division producing one
// quotient bit per two clocks, with stb/ack handshakes on both operands and the result.
module single_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  logic [3:0]        state;
  logic [31:0]       a, b;
  logic [23:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic              guard, round_bit, sticky;
  logic [50:0]       dividend;
  logic [23:0]       divisor;
  logic [26:0]       quotient;
  logic [24:0]       remainder;
  logic [5:0]        count;

  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0]       rounded_z;

  assign a_nan  = (a_e == FP32_EXP_SPECIAL) && (a_m != 24'd0);
  assign b_nan  = (b_e == FP32_EXP_SPECIAL) && (b_m != 24'd0);
  assign a_inf  = (a_e == FP32_EXP_SPECIAL) && (a_m == 24'd0);
  assign b_inf  = (b_e == FP32_EXP_SPECIAL) && (b_m == 24'd0);
  assign a_zero = (a_e == FP32_EXP_ZERO) && (a_m == 24'd0);
  assign b_zero = (b_e == FP32_EXP_ZERO) && (b_m == 24'd0);

  fp32_round_pack u_round_pack (
    .z_s      (z_s),
    .z_e      (z_e),
    .z_m      (z_m),
    .guard    (guard),
    .round_bit(round_bit),
    .sticky   (sticky),
    .z        (rounded_z)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= StGetA;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z     <= 32'd0;
      output_z_stb <= 1'b0;
      a            <= 32'd0;
      b            <= 32'd0;
      a_m          <= 24'd0;
      b_m          <= 24'd0;
      z_m          <= 24'd0;
      a_e          <= 10'sd0;
      b_e          <= 10'sd0;
      z_e          <= 10'sd0;
      a_s          <= 1'b0;
      b_s          <= 1'b0;
      z_s          <= 1'b0;
      guard        <= 1'b0;
      round_bit    <= 1'b0;
      sticky       <= 1'b0;
      dividend     <= 51'd0;
      divisor      <= 24'd0;
      quotient     <= 27'd0;
      remainder    <= 25'd0;
      count        <= 6'd0;
    end else begin
      case (state)
        StGetA: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= StGetB;
          end
        end

        StGetB: begin
          input_b_ack <= 1'b1;
          if (input_b_ack && input_b_stb) begin
            b           <= input_b;
            input_b_ack <= 1'b0;
            state       <= StUnpack;
          end
        end

        StUnpack: begin
          a_m   <= {1'b0, a[22:0]};
          b_m   <= {1'b0, b[22:0]};
          a_e   <= $signed({2'b00, a[30:23]}) - FP32_BIAS;
          b_e   <= $signed({2'b00, b[30:23]}) - FP32_BIAS;
          a_s   <= a[31];
          b_s   <= b[31];
          state <= StSpecialCases;
        end

        StSpecialCases: begin
          if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            output_z     <= FP32_NAN;
            output_z_stb <= 1'b1;
            state        <= StPutZ;
          end else if (a_inf || b_zero) begin
            output_z     <= fp32_inf(a_s ^ b_s);
            output_z_stb <= 1'b1;
            state        <= StPutZ;
          end else if (b_inf || a_zero) begin
            output_z     <= fp32_zero(a_s ^ b_s);
            output_z_stb <= 1'b1;
            state        <= StPutZ;
          end else begin
            // Denormals keep the minimum exponent and no hidden bit.
            if (a_e == FP32_EXP_ZERO) begin
              a_e <= FP32_EMIN;
            end else begin
              a_m[23] <= 1'b1;
            end
            if (b_e == FP32_EXP_ZERO) begin
              b_e <= FP32_EMIN;
            end else begin
              b_m[23] <= 1'b1;
            end
            state <= StNormaliseA;
          end
        end

        StNormaliseA: begin
          if (a_m[23]) begin
            state <= StNormaliseB;
          end else begin
            a_m <= {a_m[22:0], 1'b0};
            a_e <= a_e - 10'sd1;
          end
        end

        StNormaliseB: begin
          if (b_m[23]) begin
            state <= StDivide0;
          end else begin
            b_m <= {b_m[22:0], 1'b0};
            b_e <= b_e - 10'sd1;
          end
        end

        StDivide0: begin
          z_s       <= a_s ^ b_s;
          z_e       <= a_e - b_e;
          dividend  <= {a_m, 27'd0};
          divisor   <= b_m;
          quotient  <= 27'd0;
          remainder <= 25'd0;
          count     <= 6'd0;
          state     <= StDivide1;
        end

        StDivide1: begin
          quotient  <= {quotient[25:0], 1'b0};
          remainder <= {remainder[23:0], dividend[50]};
          dividend  <= {dividend[49:0], 1'b0};
          state     <= StDivide2;
        end

        StDivide2: begin
          if (remainder >= {1'b0, divisor}) begin
            quotient[0] <= 1'b1;
            remainder   <= remainder - {1'b0, divisor};
          end
          if (count == 6'd49) begin
            state <= StDivide3;
          end else begin
            count <= count + 6'd1;
            state <= StDivide1;
          end
        end

        StDivide3: begin
          // Quotient lies in (2^25, 2^27): top 24 bits plus two extra for rounding.
          z_m       <= quotient[26:3];
          guard     <= quotient[2];
          round_bit <= quotient[1];
          sticky    <= quotient[0] | (remainder != 25'd0);
          state     <= StNormalise1;
        end

        StNormalise1: begin
          if (!z_m[23]) begin
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - 10'sd1;
          end
          state <= StNormalise2;
        end

        StNormalise2: begin
          if (z_e < FP32_EMIN) begin
            z_m       <= {1'b0, z_m[23:1]};
            z_e       <= z_e + 10'sd1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end else begin
            state <= StRound;
          end
        end

        // Rounding and packing are combinational, so one state commits the result.
        StRound, StPack: begin
          output_z     <= rounded_z;
          output_z_stb <= 1'b1;
          state        <= StPutZ;
        end

        StPutZ: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= StGetA;
          end
        end

        default: state <= StGetA;
      endcase
    end
  end

endmodule

// File: tb/tb_single_divider.sv
// Self-checking bench for single_divider: directed cases plus randomized operands
// compared against an exact integer-arithmetic model of binary32 division.
module tb_single_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  single_divider dut (
    .clk         (clk),
    .rst         (rst),
    .input_a     (input_a),
    .input_a_stb (input_a_stb),
    .input_a_ack (input_a_ack),
    .input_b     (input_b),
    .input_b_stb (input_b_stb),
    .input_b_ack (input_b_ack),
    .output_z    (output_z),
    .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Value of a finite nonzero operand as m * 2^(ex-23), m in [2^23, 2^24).
  function automatic void decode(input logic [31:0] x, output longint unsigned m,
                                 output int ex);
    if (x[30:23] == 8'd0) begin
      m  = 64'(x[22:0]);
      ex = -126;
      while (m < 64'd8388608) begin
        m  = m << 1;
        ex = ex - 1;
      end
    end else begin
      m  = 64'(x[22:0]) + 64'd8388608;
      ex = int'(x[30:23]) - 127;
    end
  endfunction

  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned ma, mb, num, den, q, r;
    int xa, xb, e, k;
    logic [7:0] ef;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_nan || b_nan) return 32'hFFC0_0000;
    if (a_inf && b_inf) return 32'hFFC0_0000;
    if (a_inf) return {s, 8'hFF, 23'd0};
    if (b_inf) return {s, 31'd0};
    if (a_zero && b_zero) return 32'hFFC0_0000;
    if (b_zero) return {s, 8'hFF, 23'd0};
    if (a_zero) return {s, 31'd0};
    decode(a, ma, xa);
    decode(b, mb, xb);
    e = xa - xb - ((ma < mb) ? 1 : 0);
    if (e < -126) e = -126;
    // Significand scaled by 2^23 equals (ma/mb) * 2^k.
    k = 23 + xa - xb - e;
    q = 0;
    if (k >= -1) begin
      num = ma << (k + 1);
      den = mb << 1;
      q   = num / den;
      r   = num % den;
      if ((2 * r > den) || ((2 * r == den) && q[0])) q = q + 1;
    end
    if (q == 64'd16777216) begin
      q = 64'd8388608;
      e = e + 1;
    end
    if (e > 127) return {s, 8'hFF, 23'd0};
    ef = (q < 64'd8388608) ? 8'd0 : 8'(e + 127);
    return {s, ef, q[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int unsigned sel;
    v   = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0:       v[30:0]  = 31'd0;
      1:       v[30:23] = 8'd0;
      2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3:       v[30:23] = 8'hFF;
      4:       ;
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Presents a then b; returns just after the clock edge that accepts b.
  task automatic send_ab(input logic [31:0] a, input logic [31:0] b, input bit early_b);
    int cnt;
    input_a     = a;
    input_a_stb = 1'b1;
    if (early_b) begin
      input_b     = b;
      input_b_stb = 1'b1;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (early_b) check("b_ack_before_a", {31'd0, input_b_ack}, 32'd0);
    end while (!input_a_ack && cnt < 300);
    if (!input_a_ack) check("a_accept_timeout", {31'd0, input_a_ack}, 32'd1);
    @(posedge clk);
    #1 input_a_stb = 1'b0;
    input_b     = b;
    input_b_stb = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!input_b_ack && cnt < 300);
    if (!input_b_ack) check("b_accept_timeout", {31'd0, input_b_ack}, 32'd1);
    @(posedge clk);
    #1 input_b_stb = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input bit early_b,
                        output int lat);
    send_ab(a, b, early_b);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!output_z_stb && lat < 2000);
    if (!output_z_stb) check({tag, "_stb_timeout"}, {31'd0, output_z_stb}, 32'd1);
    check(tag, output_z, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_z"}, output_z, exp);
      check({tag, "_hold_stb"}, {31'd0, output_z_stb}, 32'd1);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    if (hold > 0) check({tag, "_stb_drop"}, {31'd0, output_z_stb}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb;
    rst          = 1'b0;
    input_a      = 32'd0;
    input_a_stb  = 1'b0;
    input_b      = 32'd0;
    input_b_stb  = 1'b0;
    output_z_ack = 1'b0;
    #1;
    check("rst_z", output_z, 32'd0);
    check("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
    check("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
    check("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op("div_6_2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 1'b0, lat);
    check("latency_6_2", 32'(lat), 32'd109);
    run_op("div_1_3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0, 1'b0, lat);
    run_op("div_1_1", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0, 1'b0, lat);
    run_op("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0, 1'b0, lat);
    run_op("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 0, 1'b0, lat);
    run_op("neg_by_inf", 32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 0, 1'b0, lat);
    run_op("nan_by_one", 32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 0, 1'b0, lat);
    run_op("overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 0, 1'b0, lat);
    run_op("denorm_result", 32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 0, 1'b0, lat);
    run_op("denorm_inputs", 32'h0040_0000, 32'h0040_0000, 32'h3F80_0000, 0, 1'b0, lat);
    run_op("hold_ack", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 10, 1'b0, lat);
    run_op("early_b", 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000, 0, 1'b1, lat);

    for (int i = 0; i < 150; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      run_op($sformatf("rand_%0d_%08h_%08h", i, ra, rb), ra, rb, ref_div(ra, rb), 0, 1'b0,
             lat);
    end

    // Abort a division partway through the iteration loop.
    send_ab(32'h40C0_0000, 32'h4000_0000, 1'b0);
    repeat (45) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_z", output_z, 32'd0);
    check("midrst_z_stb", {31'd0, output_z_stb}, 32'd0);
    check("midrst_a_ack", {31'd0, input_a_ack}, 32'd0);
    check("midrst_b_ack", {31'd0, input_b_ack}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 1'b0, lat);
    check("latency_after_rst", 32'(lat), 32'd109);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass,
             n_checks);
    $fatal(1, "watchdog");
  end

endmodule
